stack_pop_sequencer: RTL and testbench

- Memory-stage reader side of the stack protocol: performs the multi-word pops for RET and RTI.
- Reads words from data memory at SP+1, SP+2 and, for RTI only, SP+3.
- Reassembles the 32-bit return PC, plus the 3-bit flags for RTI.
- Presents the final SP to the SP register path as a one-cycle write.
- Holds `stall` high to freeze fetch/decode while the sequence runs.

---
 rtl/stack_pkg.sv | 29 ++
 rtl/pop_word_assembler.sv | 60 ++++++
 rtl/stack_pop_sequencer.sv | 158 +++++++++++++++
 tb/tb_stack_pop_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack pop path: FSM state encoding, pop counts,
// flag width and the SP reset constant used by the SP register logic.
package stack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_LAST,
    ST_DONE
  } pop_state_e;

  localparam int unsigned RET_POPS = 2;
  localparam int unsigned RTI_POPS = 3;
  localparam int unsigned FLAGS_W  = 3;
  localparam logic [31:0] SP_RESET = 32'h0000_0008;

  // Number of words popped for a given request kind.
  function automatic int unsigned pop_count(input logic rti);
    return rti ? RTI_POPS : RET_POPS;
  endfunction

  // Capture-bank slot that receives the final word (PC[31:16]).
  function automatic logic [1:0] last_pop_idx(input logic rti);
    return rti ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/pop_word_assembler.sv
// Capture bank keyed by pop index. Slot 0 holds the first word popped, and so
// on. The request kind decides which slots form the PC and which holds flags.
module pop_word_assembler
  import stack_pkg::*;
#(
  parameter int unsigned WORD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                cap_en_i,
  input  logic [1:0]          cap_idx_i,
  input  logic                is_rti_i,
  input  logic [WORD_W-1:0]   word_i,
  output logic [2*WORD_W-1:0] pc_o,
  output logic [FLAGS_W-1:0]  flags_o
);

  logic [WORD_W-1:0] w0_q, w1_q, w2_q;
  logic [WORD_W-1:0] w0_d, w1_d, w2_d;

  // Select the slot to load; clearing wins so a new sequence starts from zero.
  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    w2_d = w2_q;
    if (clear_i) begin
      w0_d = '0;
      w1_d = '0;
      w2_d = '0;
    end else if (cap_en_i) begin
      case (cap_idx_i)
        2'd0:    w0_d = word_i;
        2'd1:    w1_d = word_i;
        2'd2:    w2_d = word_i;
        default: ;
      endcase
    end
  end

  // Capture bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
    end else begin
      w0_q <= w0_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
    end
  end

  // RET pops PC low then high; RTI pops flags, PC low, PC high.
  always_comb begin
    pc_o    = is_rti_i ? {w2_q, w1_q} : {w1_q, w0_q};
    flags_o = is_rti_i ? w0_q[FLAGS_W-1:0] : '0;
  end

endmodule

// File: rtl/stack_pop_sequencer.sv
// Memory-stage pop sequencer for RET/RTI: reads the return PC (and flags for
// RTI) from the stack, then issues a one-cycle SP write with the final SP.
// Optional macro STACK_BOUND_CHECK_EN: reject requests whose pops would pass
// SP_LIMIT, reporting a one-cycle stack_err instead of reading memory.
module stack_pop_sequencer
  import stack_pkg::*;
#(
  parameter int unsigned     WORD_W   = 16,
  parameter int unsigned     SP_W     = 32,
  parameter logic [SP_W-1:0] SP_LIMIT = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_req,
  input  logic              rti_req,
  input  logic [SP_W-1:0]   sp_in,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic [SP_W-1:0]   mem_addr,
  output logic              stall,
  output logic              done,
  output logic [31:0]       pc_out,
  output logic [FLAGS_W-1:0] flags_out,
  output logic              is_rti,
  output logic [SP_W-1:0]   sp_out,
  output logic              sp_we,
  output logic              stack_err
);

  pop_state_e      state_q, state_d;
  logic [SP_W-1:0] sp_base_q, sp_base_d;
  logic [SP_W-1:0] addr_q;
  logic            rti_q, rti_d;
  logic            err_q, err_d;
  logic            accept;
  logic            bound_fail;
  logic            cap_en;
  logic [1:0]      cap_idx;

  assign accept = (state_q == ST_IDLE) && (ret_req || rti_req);

`ifdef STACK_BOUND_CHECK_EN
  logic [SP_W:0] sp_reach;
  // One extra bit so a wrap past 2^SP_W counts as out of bounds.
  always_comb begin
    sp_reach   = {1'b0, sp_in} + (SP_W+1)'(pop_count(rti_req));
    bound_fail = sp_reach > {1'b0, SP_LIMIT};
  end
  assign stack_err = (state_q == ST_DONE) && err_q;
`else
  logic unused_limit;
  assign unused_limit = ^SP_LIMIT;
  assign bound_fail   = 1'b0;
  assign stack_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and request latching; requests outside IDLE are ignored.
  always_comb begin
    state_d   = state_q;
    sp_base_d = sp_base_q;
    rti_d     = rti_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sp_base_d = sp_in;
          rti_d     = rti_req;
          err_d     = bound_fail;
          state_d   = bound_fail ? ST_DONE : ST_RD0;
        end
      end
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = rti_q ? ST_RD2 : ST_LAST;
      ST_RD2:  state_d = ST_LAST;
      ST_LAST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_addr holds its last value outside reads.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = addr_q;
    cap_en   = 1'b0;
    cap_idx  = 2'd0;
    done     = 1'b0;
    sp_we    = 1'b0;
    sp_out   = '0;
    stall    = (state_q != ST_IDLE);
    case (state_q)
      ST_RD0: begin
        mem_rd   = 1'b1;
        mem_addr = sp_base_q + SP_W'(1);
      end
      ST_RD1: begin
        mem_rd   = 1'b1;
        mem_addr = sp_base_q + SP_W'(2);
        cap_en   = 1'b1;
        cap_idx  = 2'd0;
      end
      ST_RD2: begin
        mem_rd   = 1'b1;
        mem_addr = sp_base_q + SP_W'(3);
        cap_en   = 1'b1;
        cap_idx  = 2'd1;
      end
      ST_LAST: begin
        cap_en  = 1'b1;
        cap_idx = last_pop_idx(rti_q);
      end
      ST_DONE: begin
        done   = 1'b1;
        sp_we  = ~err_q;
        sp_out = sp_base_q + SP_W'(pop_count(rti_q));
      end
      default: ;
    endcase
  end

  // Request context and address hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_base_q <= '0;
      rti_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      sp_base_q <= sp_base_d;
      rti_q     <= rti_d;
      err_q     <= err_d;
      addr_q    <= mem_addr;
    end
  end

  assign is_rti = rti_q;

  pop_word_assembler #(
    .WORD_W (WORD_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .cap_en_i  (cap_en),
    .cap_idx_i (cap_idx),
    .is_rti_i  (rti_q),
    .word_i    (mem_rdata),
    .pc_o      (pc_out),
    .flags_o   (flags_out)
  );

endmodule

// File: tb/tb_stack_pop_sequencer.sv
// Randomized and directed checks of stack_pop_sequencer against a word-level
// stack model: expected PC/flags/SP come straight from memory contents.
module tb_stack_pop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_req, rti_req;
  logic [31:0] sp_in;
  logic [15:0] mem_rdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        stall, done, is_rti, sp_we, stack_err;
  logic [31:0] pc_out, sp_out;
  logic [2:0]  flags_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [logic [31:0]];

  stack_pop_sequencer #(
    .WORD_W   (16),
    .SP_W     (32),
    .SP_LIMIT (32'h0000_0FFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ret_req   (ret_req),
    .rti_req   (rti_req),
    .sp_in     (sp_in),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .stall     (stall),
    .done      (done),
    .pc_out    (pc_out),
    .flags_out (flags_out),
    .is_rti    (is_rti),
    .sp_out    (sp_out),
    .sp_we     (sp_we),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // Synchronous memory: data valid the cycle after the strobe, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? rd(mem_addr) : 16'($urandom);

  // One pop sequence from IDLE; returns at the negedge of the IDLE cycle after done.
  task automatic run_pop(input bit rti, input bit ret, input logic [31:0] sp,
                         input int glitch_cyc, input string tag);
    logic [31:0] exp_addr[$];
    logic [31:0] got_addr[$];
    logic [31:0] exp_pc, exp_sp;
    logic [2:0]  exp_flags;
    int n, lat, cyc, stall_n;
    bit err, seen;
    n   = rti ? 3 : 2;
    err = 1'b0;
`ifdef STACK_BOUND_CHECK_EN
    err = ({1'b0, sp} + 33'(n)) > 33'h0_0000_0FFF;
`endif
    lat = err ? 1 : (rti ? 5 : 4);
    if (!err) for (int i = 1; i <= n; i++) exp_addr.push_back(sp + 32'(i));
    exp_sp    = sp + 32'(n);
    exp_flags = rti ? rd(sp + 32'd1) : 16'd0;
    if (err)      exp_pc = 32'd0;
    else if (rti) exp_pc = {rd(sp + 32'd3), rd(sp + 32'd2)};
    else          exp_pc = {rd(sp + 32'd2), rd(sp + 32'd1)};

    rti_req = rti; ret_req = ret; sp_in = sp;
    @(negedge clk);
    rti_req = 1'b0; sp_in = $urandom;
    cyc = 1; stall_n = 0; seen = 1'b0;
    while (!seen && cyc <= 12) begin
      ret_req = (cyc == glitch_cyc) && (cyc < lat);
      if (mem_rd === 1'b1) got_addr.push_back(mem_addr);
      if (stall === 1'b1) stall_n++;
      if (done === 1'b1) begin
        seen = 1'b1;
        ret_req = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end

    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: done not seen within 12 cycles, required at cycle %0d", tag, lat);
    end else begin
      checks++;
      if (cyc !== lat) begin failures++; $display("FAIL %s latency: got %0d required %0d", tag, cyc, lat); end
      checks++;
      if (pc_out !== exp_pc) begin failures++; $display("FAIL %s pc_out: got %h required %h", tag, pc_out, exp_pc); end
      checks++;
      if (is_rti !== rti) begin failures++; $display("FAIL %s is_rti: got %b required %b", tag, is_rti, rti); end
      checks++;
      if (sp_we !== !err) begin failures++; $display("FAIL %s sp_we: got %b required %b", tag, sp_we, !err); end
      checks++;
      if (stack_err !== err) begin failures++; $display("FAIL %s stack_err: got %b required %b", tag, stack_err, err); end
      if (!err) begin
        checks++;
        if (sp_out !== exp_sp) begin failures++; $display("FAIL %s sp_out: got %h required %h", tag, sp_out, exp_sp); end
      end
      if (rti && !err) begin
        checks++;
        if (flags_out !== exp_flags) begin failures++; $display("FAIL %s flags_out: got %b required %b", tag, flags_out, exp_flags); end
      end
      checks++;
      if (stall_n !== lat) begin failures++; $display("FAIL %s stall_cycles: got %0d required %0d", tag, stall_n, lat); end
    end
    checks++;
    if (got_addr.size() !== exp_addr.size()) begin
      failures++;
      $display("FAIL %s read_count: got %0d required %0d", tag, got_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (got_addr[i] !== exp_addr[i]) begin
          failures++;
          $display("FAIL %s read_addr[%0d]: got %h required %h", tag, i, got_addr[i], exp_addr[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || sp_we !== 1'b0 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL %s back_to_idle: done=%b stall=%b sp_we=%b mem_rd=%b required all 0", tag, done, stall, sp_we, mem_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ret_req = 1'b0; rti_req = 1'b0; sp_in = '0;
    #1;
    checks++;
    if ({mem_rd, done, sp_we, stall, stack_err, is_rti} !== 6'b0 || pc_out !== 32'd0 ||
        flags_out !== 3'd0 || sp_out !== 32'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%b done=%b we=%b stall=%b err=%b rti=%b pc=%h fl=%b sp=%h addr=%h required all 0",
               mem_rd, done, sp_we, stall, stack_err, is_rti, pc_out, flags_out, sp_out, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ret_directed();
    mem[32'd9] = 16'h1234; mem[32'd10] = 16'h00AB;
    run_pop(1'b0, 1'b1, 32'd8, 0, "ret_directed");
  endtask

  task automatic test_rti_directed();
    mem[32'd6] = 16'h0005; mem[32'd7] = 16'hBEEF; mem[32'd8] = 16'h0001;
    run_pop(1'b1, 1'b0, 32'd5, 0, "rti_directed");
  endtask

  task automatic test_priority_ignore();
    run_pop(1'b1, 1'b1, 32'h0000_0200, 2, "priority_glitch");
  endtask

  task automatic test_reset_midseq();
    int bad = 0;
    ret_req = 1'b1; sp_in = 32'h0000_0100;
    @(negedge clk); ret_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h0000_0102) begin
      failures++;
      $display("FAIL pre_reset_rd1: mem_rd=%b addr=%h required 1 and 00000102", mem_rd, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, done, sp_we, stall, stack_err, is_rti} !== 6'b0 || pc_out !== 32'd0 ||
        flags_out !== 3'd0 || sp_out !== 32'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL midseq_reset_outputs: rd=%b done=%b we=%b stall=%b addr=%h required all 0",
               mem_rd, done, sp_we, stall, mem_addr);
    end
    repeat (3) begin @(negedge clk); if (sp_we !== 1'b0) bad++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (sp_we !== 1'b0 || stall !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midseq_no_sp_write: got %0d bad cycles required 0", bad); end
    run_pop(1'b0, 1'b1, 32'h0000_0040, 0, "ret_after_reset");
  endtask

  task automatic test_wrap();
    run_pop(1'b0, 1'b1, 32'hFFFF_FFFF, 0, "ret_wrap");
  endtask

  task automatic test_back_to_back();
    run_pop(1'b0, 1'b1, 32'h0000_0300, 0, "b2b_ret");
    run_pop(1'b1, 1'b0, 32'h0000_0500, 0, "b2b_rti");
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      bit          kind;
      logic [31:0] sp;
      kind = 1'($urandom_range(0, 1));
      sp   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h1200));
      for (int i = 1; i <= 3; i++) mem[sp + 32'(i)] = 16'($urandom);
      run_pop(kind, kind ? 1'($urandom_range(0, 1)) : 1'b1, sp, $urandom_range(0, 4), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ret_directed();
    test_rti_directed();
    test_priority_ignore();
    test_reset_midseq();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
